// File: rtl/serial_subtractor8_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor.
// The state encoding is fixed so waveforms read the same across builds.
package serial_subtractor8_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int IDXW_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_subtractor8_fs.sv
// One-bit full-subtractor cell: diff = x - y - bin, with borrow out.
module full_subtractor_1b (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial unsigned subtractor: D = A - B, one bit per cycle from the LSB,
// using one full-subtractor cell and a registered borrow. Index 0 is the MSB.
module serial_subtractor8
  import serial_subtractor8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] d,
  output logic             b_out
);

  localparam logic [IDXW-1:0] IDX_LSB = IDXW'(WIDTH - 1);

  state_t           r_state;
  logic [0:WIDTH-1] r_ra;
  logic [0:WIDTH-1] r_rb;
  logic [0:WIDTH-1] r_d;
  logic [IDXW-1:0]  r_idx;
  logic             r_borrow;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic w_diff;
  logic w_bout;

  full_subtractor_1b u_cell (
    .x    (r_ra[r_idx]),
    .y    (r_rb[r_idx]),
    .bin  (r_borrow),
    .diff (w_diff),
    .bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ra     <= '0;
      r_rb     <= '0;
      r_d      <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back ops.
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ra     <= a;
            r_rb     <= b;
            r_borrow <= 1'b0;
            r_idx    <= IDX_LSB;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_d[r_idx] <= w_diff;
          r_borrow   <= w_bout;
          if (r_idx == '0) begin
            r_bout  <= w_bout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign d     = r_d;
  assign b_out = r_bout;

endmodule

// File: tb/tb_serial_subtractor8.sv
// Self-checking bench for serial_subtractor8: directed vectors, corner
// sequences and randomized operands against an arithmetic reference.
module tb_serial_subtractor8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [0:7] a;
  logic [0:7] b;
  logic       busy;
  logic       done;
  logic [0:7] d;
  logic       b_out;

  int checks   = 0;
  int failures = 0;

  serial_subtractor8 #(.WIDTH(8), .IDXW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] vd;
    logic       vbo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present operands and start before the next edge; afterwards scramble
  // the inputs so a late re-sample would corrupt the result.
  task automatic issue(input logic [7:0] xa, input logic [7:0] xb);
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  // Wait for done; report edges taken and cycles busy was seen high.
  task automatic wait_done(output int edges, output int nbusy, output bit ok);
    ok = 1'b0;
    edges = 0;
    nbusy = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy && done) begin
        checks++;
        failures++;
        $display("FAIL busy_and_done: busy=%0b done=%0b required not both", busy, done);
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout: done not seen within 20 cycles");
    end
  endtask

  task automatic check_result(input string name, input logic [7:0] xa, input logic [7:0] xb);
    logic [7:0] exp_d;
    logic       exp_bo;
    exp_d  = xa - xb;
    exp_bo = (xa < xb);
    chk({name, "_d"}, 32'(d), 32'(exp_d));
    chk({name, "_bout"}, 32'(b_out), 32'(exp_bo));
  endtask

  initial begin
    vec_t vecs[5];
    int   edges;
    int   nbusy;
    bit   ok;
    logic [7:0] ra;
    logic [7:0] rb;
    bit   saw_done;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'hE0, 8'h06, 8'hDA, 1'b0};
    vecs[2] = '{8'h06, 8'hE0, 8'h26, 1'b1};
    vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0};

    start = 1'b0;
    a = '0;
    b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_d", 32'(d), 0);
    chk("reset_bout", 32'(b_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero case with latency and busy-width checks.
    issue(8'h00, 8'h00);
    wait_done(edges, nbusy, ok);
    chk("zero_latency", 32'(edges), 8);
    chk("zero_busy_cycles", 32'(nbusy), 8);
    check_result("zero", 8'h00, 8'h00);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 0);

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].va, vecs[i].vb);
      wait_done(edges, nbusy, ok);
      chk($sformatf("vec%0d_d", i), 32'(d), 32'(vecs[i].vd));
      chk($sformatf("vec%0d_bout", i), 32'(b_out), 32'(vecs[i].vbo));
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hold", i), 32'(d), 32'(vecs[i].vd));
    end

    // Start during RUN must be ignored.
    issue(8'h55, 8'h11);
    repeat (2) @(posedge clk);
    issue(8'hFF, 8'hFF);
    wait_done(edges, nbusy, ok);
    chk("guard_d", 32'(d), 32'h44);
    chk("guard_bout", 32'(b_out), 0);

    // Back-to-back start in the DONE cycle.
    issue(8'h80, 8'h7F);
    chk("b2b_busy", 32'(busy), 1);
    wait_done(edges, nbusy, ok);
    chk("b2b_latency", 32'(edges), 8);
    chk("b2b_d", 32'(d), 32'h01);
    chk("b2b_bout", 32'(b_out), 0);

    // Reset in the 4th RUN cycle aborts with no done pulse.
    issue(8'h33, 8'h99);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_d", 32'(d), 0);
    chk("abort_bout", 32'(b_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 0);
    issue(8'h10, 8'h20);
    wait_done(edges, nbusy, ok);
    chk("post_abort_d", 32'(d), 32'hF0);
    chk("post_abort_bout", 32'(b_out), 1);

    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      issue(ra, rb);
      wait_done(edges, nbusy, ok);
      check_result($sformatf("rand%0d", i), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
